// File: rtl/risc_controller.sv
// VeriRisc sequencer: steps the 8-phase instruction cycle and decodes the opcode into datapath strobes.
// A sticky HLT parks the controller in OP_ADDR until reset.
module risc_controller #(
  parameter int OPCODE_W    = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  output logic [2:0]          phase_o,
  output logic                sel_o,
  output logic                rd_o,
  output logic                ld_ir_o,
  output logic                ld_ac_o,
  output logic                ld_pc_o,
  output logic                inc_pc_o,
  output logic                wr_o,
  output logic                data_e_o,
  output logic                halt_o
);

  localparam logic [2:0] P_INST_ADDR  = 3'd0;
  localparam logic [2:0] P_INST_FETCH = 3'd1;
  localparam logic [2:0] P_INST_LOAD  = 3'd2;
  localparam logic [2:0] P_IDLE       = 3'd3;
  localparam logic [2:0] P_OP_ADDR    = 3'd4;
  localparam logic [2:0] P_OP_FETCH   = 3'd5;
  localparam logic [2:0] P_ALU_OP     = 3'd6;
  localparam logic [2:0] P_STORE      = 3'd7;

  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       is_hlt, is_skz, is_sto, is_jmp, is_alu;

  assign is_hlt = (opcode_i == OP_HLT);
  assign is_skz = (opcode_i == OP_SKZ);
  assign is_sto = (opcode_i == OP_STO);
  assign is_jmp = (opcode_i == OP_JMP);
  assign is_alu = (opcode_i == OP_ADD) || (opcode_i == OP_AND) ||
                  (opcode_i == OP_XOR) || (opcode_i == OP_LDA);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phase_q  <= P_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    phase_d  = phase_q + 3'd1;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = P_OP_ADDR;
    end else if (HALT_STICKY && (phase_q == P_OP_ADDR) && is_hlt) begin
      halted_d = 1'b1;
      phase_d  = P_OP_ADDR;
    end
  end

  always_comb begin
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    ld_ir_o  = 1'b0;
    ld_ac_o  = 1'b0;
    ld_pc_o  = 1'b0;
    inc_pc_o = 1'b0;
    wr_o     = 1'b0;
    data_e_o = 1'b0;
    halt_o   = 1'b0;
    if (halted_q) begin
      halt_o = 1'b1;
    end else begin
      case (phase_q)
        P_INST_ADDR: sel_o = 1'b1;
        P_INST_FETCH: begin
          sel_o = 1'b1;
          rd_o  = 1'b1;
        end
        P_INST_LOAD, P_IDLE: begin
          sel_o   = 1'b1;
          rd_o    = 1'b1;
          ld_ir_o = 1'b1;
        end
        P_OP_ADDR: begin
          inc_pc_o = 1'b1;
          halt_o   = is_hlt;
        end
        P_OP_FETCH: rd_o = is_alu;
        P_ALU_OP: begin
          rd_o     = is_alu;
          inc_pc_o = is_skz && zero_i;
          ld_pc_o  = is_jmp;
          data_e_o = is_sto;
        end
        P_STORE: begin
          rd_o     = is_alu;
          ld_ac_o  = is_alu;
          inc_pc_o = is_jmp;
          ld_pc_o  = is_jmp;
          wr_o     = is_sto;
          data_e_o = is_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase_o = phase_q;

endmodule
